// File: rtl/exec_stage_mc.sv
// Execute stage: operand forwarding, Val2 shifter, ALU + NZCV, branch adder, iterative shift-add MUL.
// Latency: 1 cycle for ALU ops; MUL up to WIDTH cycles in the iterate state, early-out once the multiplier drains.
// Backpressure: in_ready drops while a MUL iterates; flush kills the pending result and any running MUL.
module exec_stage_mc #(
    parameter int WIDTH   = 32,
    parameter int NUM_FWD = 2,
    parameter int SELW    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         pc_in,
    input  logic [3:0]               exec_cmd,
    input  logic                     s_in,
    input  logic                     b_in,
    input  logic                     mem_read_in,
    input  logic                     mem_write_in,
    input  logic                     wb_en_in,
    input  logic                     imm_in,
    input  logic [23:0]              simm24_in,
    input  logic [11:0]              shift_op_in,
    input  logic [WIDTH-1:0]         val_rn_in,
    input  logic [WIDTH-1:0]         val_rm_in,
    input  logic [3:0]               dst_in,
    input  logic [NUM_FWD*WIDTH-1:0] fwd_data,
    input  logic [SELW-1:0]          fwd_sel_rn,
    input  logic [SELW-1:0]          fwd_sel_rm,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         alu_out,
    output logic [WIDTH-1:0]         val_rm_out,
    output logic [3:0]               dst_out,
    output logic                     wb_en_out,
    output logic                     mem_read_out,
    output logic                     mem_write_out,
    output logic                     branch_taken,
    output logic [WIDTH-1:0]         branch_address,
    output logic [3:0]               status_out
);
    localparam int CNTW = $clog2(WIDTH);

    localparam logic [3:0] CMD_MOV = 4'b0001, CMD_MVN = 4'b1001, CMD_ADD = 4'b0010,
                           CMD_ADC = 4'b0011, CMD_SUB = 4'b0100, CMD_SBC = 4'b0101,
                           CMD_AND = 4'b0110, CMD_ORR = 4'b0111, CMD_EOR = 4'b1000,
                           CMD_MUL = 4'b1010;

    typedef enum logic {S_IDLE, S_MUL} state_t;
    state_t state, state_nx;

    logic [WIDTH-1:0] rn_op, rm_op, val2, op_b, alu_res;
    logic [WIDTH:0]   sum;
    logic             cin, arith, mem_acc, accept, is_mul;
    logic [3:0]       cmd, flags;
    logic [WIDTH-1:0] mcand, mplier, acc, acc_n, mplier_n;
    logic [CNTW-1:0]  cnt;
    logic             mul_s, mul_done;

    function automatic logic [WIDTH-1:0] ror(input logic [WIDTH-1:0] x, input logic [4:0] n);
        if (n == 5'd0) return x;
        return (x >> n) | (x << (WIDTH - int'(n)));
    endfunction

    // Selects above NUM_FWD fall back to the register-file value.
    always_comb begin
        rn_op = val_rn_in;
        rm_op = val_rm_in;
        for (int k = 1; k <= NUM_FWD; k++) begin
            if (fwd_sel_rn == SELW'(k)) rn_op = fwd_data[(k-1)*WIDTH +: WIDTH];
            if (fwd_sel_rm == SELW'(k)) rm_op = fwd_data[(k-1)*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        mem_acc = mem_read_in | mem_write_in;
        if (mem_acc)
            val2 = {{(WIDTH-12){1'b0}}, shift_op_in};
        else if (imm_in)
            val2 = ror({{(WIDTH-8){1'b0}}, shift_op_in[7:0]}, {shift_op_in[11:8], 1'b0});
        else begin
            case (shift_op_in[6:5])
                2'b00:   val2 = rm_op << shift_op_in[11:7];
                2'b01:   val2 = rm_op >> shift_op_in[11:7];
                2'b10:   val2 = $signed(rm_op) >>> shift_op_in[11:7];
                default: val2 = ror(rm_op, shift_op_in[11:7]);
            endcase
        end
    end

    // Subtraction is rn + ~val2 + cin, so C comes out as "no borrow" directly.
    always_comb begin
        cmd   = mem_acc ? CMD_ADD : exec_cmd;
        op_b  = val2;
        cin   = 1'b0;
        arith = 1'b0;
        case (cmd)
            CMD_ADD: arith = 1'b1;
            CMD_ADC: begin arith = 1'b1; cin = status_out[1]; end
            CMD_SUB: begin arith = 1'b1; op_b = ~val2; cin = 1'b1; end
            CMD_SBC: begin arith = 1'b1; op_b = ~val2; cin = status_out[1]; end
            default: ;
        endcase
        sum = {1'b0, rn_op} + {1'b0, op_b} + (WIDTH+1)'(cin);
        case (cmd)
            CMD_MOV: alu_res = val2;
            CMD_MVN: alu_res = ~val2;
            CMD_AND: alu_res = rn_op & val2;
            CMD_ORR: alu_res = rn_op | val2;
            CMD_EOR: alu_res = rn_op ^ val2;
            default: alu_res = sum[WIDTH-1:0];
        endcase
        flags[3] = alu_res[WIDTH-1];
        flags[2] = (alu_res == '0);
        flags[1] = arith ? sum[WIDTH] : status_out[1];
        flags[0] = arith ? ((rn_op[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != rn_op[WIDTH-1]))
                         : status_out[0];
    end

    assign in_ready = (state == S_IDLE);
    assign accept   = in_valid & in_ready & ~flush;
    assign is_mul   = (cmd == CMD_MUL);
    assign acc_n    = acc + (mplier[0] ? mcand : '0);
    assign mplier_n = mplier >> 1;
    assign mul_done = (cnt == CNTW'(WIDTH-1)) || (mplier_n == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept && is_mul) state_nx = S_MUL;
            default: if (flush || mul_done) state_nx = S_IDLE;
        endcase
    end

    // Side-band fields load at accept; they are only meaningful alongside out_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid      <= 1'b0;
            alu_out        <= '0;
            val_rm_out     <= '0;
            dst_out        <= '0;
            wb_en_out      <= 1'b0;
            mem_read_out   <= 1'b0;
            mem_write_out  <= 1'b0;
            branch_taken   <= 1'b0;
            branch_address <= '0;
            status_out     <= '0;
            mcand          <= '0;
            mplier         <= '0;
            acc            <= '0;
            cnt            <= '0;
            mul_s          <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    val_rm_out     <= rm_op;
                    dst_out        <= dst_in;
                    wb_en_out      <= wb_en_in;
                    mem_read_out   <= mem_read_in;
                    mem_write_out  <= mem_write_in;
                    branch_taken   <= b_in;
                    branch_address <= pc_in + {{(WIDTH-26){simm24_in[23]}}, simm24_in, 2'b00};
                    if (is_mul) begin
                        mcand  <= rn_op;
                        mplier <= rm_op;
                        acc    <= '0;
                        cnt    <= '0;
                        mul_s  <= s_in;
                    end else begin
                        alu_out   <= alu_res;
                        out_valid <= 1'b1;
                        if (s_in) status_out <= flags;
                    end
                end
                default: if (!flush) begin
                    acc    <= acc_n;
                    mcand  <= mcand << 1;
                    mplier <= mplier_n;
                    cnt    <= cnt + CNTW'(1);
                    if (mul_done) begin
                        alu_out   <= acc_n;
                        out_valid <= 1'b1;
                        if (mul_s) status_out <= {acc_n[WIDTH-1], (acc_n == '0), status_out[1:0]};
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_exec_stage_mc.sv
// Directed bench for exec_stage_mc: ALU/flags, shifter, forwarding, branch, MUL, flush and async reset.
module tb_exec_stage_mc;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, flush;
    logic [W-1:0]  pc_in;
    logic [3:0]    exec_cmd;
    logic          s_in, b_in, mem_read_in, mem_write_in, wb_en_in, imm_in;
    logic [23:0]   simm24_in;
    logic [11:0]   shift_op_in;
    logic [W-1:0]  val_rn_in, val_rm_in;
    logic [3:0]    dst_in;
    logic [2*W-1:0] fwd_data;
    logic [1:0]    fwd_sel_rn, fwd_sel_rm;
    logic          out_valid;
    logic [W-1:0]  alu_out, val_rm_out, branch_address;
    logic [3:0]    dst_out, status_out;
    logic          wb_en_out, mem_read_out, mem_write_out, branch_taken;

    int n_chk  = 0;
    int n_pass = 0;

    exec_stage_mc #(.WIDTH(W), .NUM_FWD(2), .SELW(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .pc_in(pc_in), .exec_cmd(exec_cmd), .s_in(s_in), .b_in(b_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .wb_en_in(wb_en_in),
        .imm_in(imm_in), .simm24_in(simm24_in), .shift_op_in(shift_op_in),
        .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .dst_in(dst_in),
        .fwd_data(fwd_data), .fwd_sel_rn(fwd_sel_rn), .fwd_sel_rm(fwd_sel_rm),
        .out_valid(out_valid), .alu_out(alu_out), .val_rm_out(val_rm_out), .dst_out(dst_out),
        .wb_en_out(wb_en_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
        .branch_taken(branch_taken), .branch_address(branch_address), .status_out(status_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        in_valid = 0; flush = 0; pc_in = '0; exec_cmd = 4'b0001; s_in = 0; b_in = 0;
        mem_read_in = 0; mem_write_in = 0; wb_en_in = 0; imm_in = 0; simm24_in = '0;
        shift_op_in = '0; val_rn_in = '0; val_rm_in = '0; dst_in = '0; fwd_data = '0;
        fwd_sel_rn = '0; fwd_sel_rm = '0;
    endtask

    // Present the prepared instruction for one edge, then drop in_valid.
    task automatic issue();
        in_valid = 1;
        tick();
        in_valid = 0;
    endtask

    // Runs a started MUL to completion within a cycle budget, watching in_ready stay low.
    task automatic wait_mul(input string tag, input int budget);
        int  cyc = 0;
        logic rdy_bad = 1'b0;
        while (!out_valid && cyc < budget) begin
            if (in_ready) rdy_bad = 1'b1;
            tick();
            cyc++;
        end
        chk({tag, "_done"}, W'(out_valid), W'(1));
        chk({tag, "_rdy_low"}, W'(rdy_bad), W'(0));
    endtask

    initial begin
        clr();
        rst = 0;
        #2;
        chk("rst_valid", W'(out_valid), 0);
        chk("rst_alu", alu_out, 0);
        chk("rst_status", W'(status_out), 0);
        chk("rst_ready", W'(in_ready), 1);
        #10 rst = 1;
        tick();

        // ADD with immediate: signed overflow into the sign bit
        clr(); exec_cmd = 4'b0010; val_rn_in = 32'h7FFF_FFFF; imm_in = 1; shift_op_in = 12'h001;
        s_in = 1; dst_in = 4'd3; wb_en_in = 1;
        issue();
        chk("add_valid", W'(out_valid), 1);
        chk("add_res", alu_out, 32'h8000_0000);
        chk("add_nzcv", W'(status_out), W'(4'b1001));
        chk("add_dst", W'(dst_out), 3);
        chk("add_wb", W'(wb_en_out), 1);
        clr(); tick();
        chk("idle_valid", W'(out_valid), 0);
        chk("idle_hold", alu_out, 32'h8000_0000);

        // SUB with rn forwarded from source 1
        clr(); exec_cmd = 4'b0100; val_rn_in = 32'h999; fwd_sel_rn = 2'd2;
        fwd_data = {32'h10, 32'hDEAD}; imm_in = 1; shift_op_in = 12'h010; s_in = 1;
        issue();
        chk("sub_res", alu_out, 0);
        chk("sub_nzcv", W'(status_out), W'(4'b0110));

        // Shifter: ASR, ROR (rm forwarded from source 0), LSR, rotated immediate
        clr(); val_rm_in = 32'h8000_0001; shift_op_in = 12'h0C0; issue();
        chk("asr", alu_out, 32'hC000_0000);
        clr(); val_rm_in = 32'h0; fwd_sel_rm = 2'd1; fwd_data = {32'h0, 32'h8000_0001};
        shift_op_in = 12'h0E0; issue();
        chk("ror_fwd", alu_out, 32'hC000_0000);
        chk("ror_rm_out", val_rm_out, 32'h8000_0001);
        clr(); val_rm_in = 32'h8000_0001; shift_op_in = 12'h0A0; issue();
        chk("lsr", alu_out, 32'h4000_0000);
        clr(); imm_in = 1; shift_op_in = 12'h1FF; issue();
        chk("imm_rot", alu_out, 32'hC000_003F);
        chk("noflag_keep", W'(status_out), W'(4'b0110));

        // Carry-in ops: ADC with C=1, then SBC with C=0
        clr(); exec_cmd = 4'b0011; val_rn_in = 5; imm_in = 1; shift_op_in = 12'h003; s_in = 1; issue();
        chk("adc_res", alu_out, 9);
        chk("adc_nzcv", W'(status_out), W'(4'b0000));
        clr(); exec_cmd = 4'b0101; val_rn_in = 5; imm_in = 1; shift_op_in = 12'h003; s_in = 1; issue();
        chk("sbc_res", alu_out, 1);
        chk("sbc_nzcv", W'(status_out), W'(4'b0010));

        // Logical ops keep C and V
        clr(); exec_cmd = 4'b1000; val_rn_in = 32'hF0F0; imm_in = 1; shift_op_in = 12'h0FF; s_in = 1; issue();
        chk("eor_res", alu_out, 32'hF00F);
        chk("eor_nzcv", W'(status_out), W'(4'b0010));
        clr(); exec_cmd = 4'b1001; imm_in = 1; s_in = 1; issue();
        chk("mvn_res", alu_out, 32'hFFFF_FFFF);
        chk("mvn_nzcv", W'(status_out), W'(4'b1010));

        // Branch target with negative offset; load address uses ADD of zext offset
        clr(); pc_in = 32'h100; simm24_in = 24'hFFFFFE; b_in = 1; issue();
        chk("br_addr", branch_address, 32'hF8);
        chk("br_taken", W'(branch_taken), 1);
        clr(); mem_read_in = 1; val_rn_in = 32'h1000; shift_op_in = 12'hFFF; issue();
        chk("ldr_addr", alu_out, 32'h1FFF);
        chk("ldr_mr", W'(mem_read_out), 1);

        // MUL 0x1234 x 0x10, no flag update
        clr(); exec_cmd = 4'b1010; val_rn_in = 32'h1234; val_rm_in = 32'h10; issue();
        chk("mul_busy_valid", W'(out_valid), 0);
        wait_mul("mul1", 40);
        chk("mul1_res", alu_out, 32'h12340);
        chk("mul1_nzcv", W'(status_out), W'(4'b1010));
        tick();
        chk("mul1_pulse", W'(out_valid), 0);
        chk("mul1_ready", W'(in_ready), 1);

        // MUL by zero (early out) sets Z; full-length MUL 3 x -1 sets N
        clr(); exec_cmd = 4'b1010; val_rn_in = 32'h5; val_rm_in = 32'h0; s_in = 1; issue();
        wait_mul("mul0", 40);
        chk("mul0_res", alu_out, 0);
        chk("mul0_nzcv", W'(status_out), W'(4'b0110));
        clr(); exec_cmd = 4'b1010; val_rn_in = 32'h3; val_rm_in = 32'hFFFF_FFFF; s_in = 1; issue();
        wait_mul("mulf", 40);
        chk("mulf_res", alu_out, 32'hFFFF_FFFD);
        chk("mulf_nzcv", W'(status_out), W'(4'b1010));

        // Flush a MUL in its fifth cycle
        clr(); exec_cmd = 4'b1010; val_rn_in = 32'h7; val_rm_in = 32'hFFFF; s_in = 1; issue();
        repeat (4) tick();
        flush = 1; tick(); flush = 0;
        chk("fl_ready", W'(in_ready), 1);
        begin
            logic seen = 1'b0;
            repeat (20) begin
                if (out_valid) seen = 1'b1;
                tick();
            end
            chk("fl_no_valid", W'(seen), 0);
        end
        chk("fl_nzcv", W'(status_out), W'(4'b1010));
        clr(); exec_cmd = 4'b0010; val_rn_in = 2; imm_in = 1; shift_op_in = 12'h003; issue();
        chk("fl_add_valid", W'(out_valid), 1);
        chk("fl_add_res", alu_out, 5);

        // Flush wins over a same-cycle accept
        clr(); exec_cmd = 4'b0010; val_rn_in = 40; imm_in = 1; shift_op_in = 12'h001; s_in = 1;
        flush = 1; issue(); flush = 0;
        chk("flacc_valid", W'(out_valid), 0);
        chk("flacc_hold", alu_out, 5);
        chk("flacc_nzcv", W'(status_out), W'(4'b1010));

        // Asynchronous reset in the middle of a MUL
        clr(); exec_cmd = 4'b1010; val_rn_in = 32'h7; val_rm_in = 32'hFFFF; pc_in = 32'h40; issue();
        tick(); tick();
        #2 rst = 0;
        #1;
        chk("arst_alu", alu_out, 0);
        chk("arst_status", W'(status_out), 0);
        chk("arst_baddr", branch_address, 0);
        chk("arst_ready", W'(in_ready), 1);
        #10 rst = 1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
